// File: rtl/seq_shifter.sv
// Multi-cycle shifter that moves data_out by one bit per clock until the latched amount is spent.
// Optional macro SEQ_SHIFTER_ROTATE_EN turns op=11 into rotate-right; otherwise op=11 acts as SRL.
module seq_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [SHAMT_W-1:0] CntOne = SHAMT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;

  // One-bit step of the latched operation.
  always_comb begin
    shifted = data_q;
    case (op_q)
      2'b00:   shifted = {data_q[WIDTH-2:0], 1'b0};
      2'b10:   shifted = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b11:   shifted = {data_q[0], data_q[WIDTH-1:1]};
      default: shifted = {1'b0, data_q[WIDTH-1:1]};
`else
      default: shifted = {1'b0, data_q[WIDTH-1:1]};
`endif
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          data_d  = data_in;
          op_d    = op;
          cnt_d   = shamt;
          state_d = (shamt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        data_d = shifted;
        cnt_d  = cnt_q - CntOne;
        // Leave on the edge that performs the last one-bit step.
        if (cnt_q == CntOne) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign data_out = data_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule
